fetch_unit: RTL

Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the IF/ID register and the hazard/forwarding logic.
- Owns the PC and issues word requests to instruction memory over a req/gnt + rvalid interface.
- Buffers returned words with their PCs in a small in-order FIFO and presents the head to decode.
- Obeys the stall and flush/redirect signals produced by the hazard unit and branch resolution.

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage port bundle: hazard-unit control, instruction-memory req/gnt/rvalid and the decode-facing head.
interface fetch_unit_if;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  modport master (
    input  stall_i, flush_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, valid_o, instr_o, pc_o
  );

  modport slave (
    output stall_i, flush_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, valid_o, instr_o, pc_o
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC owner, credit-limited imem requester, in-order fetch buffer; head visible 1 cycle after rvalid.
// Backpressure: stall_i holds the head while fetching continues until outstanding + buffered reaches FIFO_DEPTH.

module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_vld,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_vld) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_vld) - CW'(pop_vld);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.master bus
);
  localparam int          CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  logic [31:0]   pc_q;
  logic [31:0]   resp_pc_q;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credits_used;
  logic          req_vld;
  logic          gnt_fire;
  logic          rsp_vld;
  logic          push_vld;
  logic          pop_vld;
  logic          head_vld;
  fetch_ent_t    push_dat;
  fetch_ent_t    head_dat;

  assign redirect_pc  = bus.redirect_pc_i & ~32'h3;
  assign credits_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign req_vld      = !rst_i && !bus.flush_i && (credits_used < (CW+1)'(FIFO_DEPTH));
  assign gnt_fire     = req_vld && bus.imem_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored outright.
  assign rsp_vld      = bus.imem_rvalid_i && (outstanding != '0);
  assign push_vld     = rsp_vld && (drop_cnt == '0) && !bus.flush_i;
  assign head_vld     = (fifo_count != '0) && !rst_i;
  assign pop_vld      = head_vld && !bus.stall_i && !bus.flush_i;
  assign push_dat     = '{pc: resp_pc_q, instr: bus.imem_rdata_i};

  fetch_fifo #(
    .WIDTH ($bits(fetch_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_vld  (bus.flush_i),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q        <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      // Stale requests stay counted until they return so the credit limit stays exact.
      outstanding <= outstanding + CW'(gnt_fire) - CW'(rsp_vld);
      if (bus.flush_i) begin
        pc_q      <= redirect_pc;
        resp_pc_q <= redirect_pc;
        drop_cnt  <= outstanding - CW'(rsp_vld);
      end else begin
        if (gnt_fire) pc_q <= pc_q + 32'd4;
        if (push_vld) resp_pc_q <= resp_pc_q + 32'd4;
        if (rsp_vld && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  assign bus.imem_req_o  = req_vld;
  assign bus.imem_addr_o = pc_q;
  assign bus.valid_o     = head_vld;
  assign bus.instr_o     = head_vld ? head_dat.instr : NOP;
  assign bus.pc_o        = head_vld ? head_dat.pc : 32'h0;
endmodule
